// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour vote block: FSM encoding,
// parameter defaults and the vote-counter width helper.
package knn_pkg;

   localparam int K_DEF      = 5;
   localparam int W_DEF      = 16;
   localparam int TYPE_W_DEF = 2;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_VOTE    = 2'd2,
      ST_RESULT  = 2'd3
   } knn_state_t;

   // Bits needed to hold a vote count in the range 0..k.
   function automatic int vote_width(input int k);
      return $clog2(k + 1);
   endfunction

endpackage

// File: rtl/knn_argmax.sv
// Sequential arg-max: one label per enabled cycle, holding the best index and
// count seen so far. Strict-greater update keeps the lowest index on ties.
module knn_argmax
   import knn_pkg::*;
#(
   parameter int TYPE_W = TYPE_W_DEF,
   parameter int VW     = vote_width(K_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_en,
   input  logic [TYPE_W-1:0] i_idx,
   input  logic [VW-1:0]     i_cnt,
   output logic [TYPE_W-1:0] o_best_type,
   output logic [VW-1:0]     o_best_cnt
);

   logic [TYPE_W-1:0] r_best_type;
   logic [VW-1:0]     r_best_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_best_type <= '0;
         r_best_cnt  <= '0;
      end else if (i_clear) begin
         r_best_type <= '0;
         r_best_cnt  <= '0;
      end else if (i_en && (i_cnt > r_best_cnt)) begin
         r_best_type <= i_idx;
         r_best_cnt  <= i_cnt;
      end
   end

   assign o_best_type = r_best_type;
   assign o_best_cnt  = r_best_cnt;

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the K nearest samples of an ascending-distance stream,
// with a sticky ordering-error flag for streams that are not sorted.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_COLLECT | accept samples, count labels of the first K
//   ST_DRAIN   | K samples counted; consume the rest of the stream
//   ST_VOTE    | scan labels 0..N_TYPES-1, then one cycle to latch result
//   ST_RESULT  | hold result until class_ready, then clear and restart
module knn_vote
   import knn_pkg::*;
#(
   parameter int  W       = W_DEF,
   parameter int  TYPE_W  = TYPE_W_DEF,
   parameter int  K       = K_DEF,
   localparam int N_TYPES = 2 ** TYPE_W,
   localparam int VW      = vote_width(K)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_dist,
   input  logic [TYPE_W-1:0] in_type,
   input  logic              in_last,
   output logic              class_valid,
   input  logic              class_ready,
   output logic [TYPE_W-1:0] class_type,
   output logic [VW-1:0]     class_votes,
   output logic              order_err
);

   localparam logic [VW-1:0]     K_V      = VW'(K);
   localparam logic [VW-1:0]     K_LAST   = VW'(K - 1);
   localparam logic [TYPE_W:0]   SCAN_END = (TYPE_W + 1)'(N_TYPES);

   knn_state_t        r_state;
   logic [VW-1:0]     r_cnt [N_TYPES];
   logic [VW-1:0]     r_n;
   logic [W-1:0]      r_prev;
   logic              r_have_prev;
   logic              r_err;
   logic [TYPE_W:0]   r_scan;
   logic              r_class_valid;
   logic [TYPE_W-1:0] r_class_type;
   logic [VW-1:0]     r_class_votes;

   logic              w_xfer;
   logic              w_done;
   logic              w_scan_en;
   logic [TYPE_W-1:0] w_scan_idx;
   logic [TYPE_W-1:0] w_best_type;
   logic [VW-1:0]     w_best_cnt;

   assign in_ready   = !rst && ((r_state == ST_COLLECT) || (r_state == ST_DRAIN));
   assign w_xfer     = in_valid && in_ready;
   assign w_done     = (r_state == ST_RESULT) && class_ready;
   assign w_scan_en  = (r_state == ST_VOTE) && (r_scan != SCAN_END);
   assign w_scan_idx = r_scan[TYPE_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_COLLECT;
         r_n           <= '0;
         r_scan        <= '0;
         r_class_valid <= 1'b0;
         r_class_type  <= '0;
         r_class_votes <= '0;
         for (int i = 0; i < N_TYPES; i++) r_cnt[i] <= '0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (w_xfer) begin
                  if (r_cnt[in_type] != K_V) r_cnt[in_type] <= r_cnt[in_type] + 1'b1;
                  r_n <= r_n + 1'b1;
                  if (in_last) begin
                     r_state <= ST_VOTE;
                     r_scan  <= '0;
                  end else if (r_n == K_LAST) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_xfer && in_last) begin
                  r_state <= ST_VOTE;
                  r_scan  <= '0;
               end
            end
            ST_VOTE: begin
               // The extra cycle at SCAN_END lets the last label's compare settle.
               if (r_scan == SCAN_END) begin
                  r_state       <= ST_RESULT;
                  r_class_valid <= 1'b1;
                  r_class_type  <= w_best_type;
                  r_class_votes <= w_best_cnt;
               end else begin
                  r_scan <= r_scan + 1'b1;
               end
            end
            ST_RESULT: begin
               if (class_ready) begin
                  r_state       <= ST_COLLECT;
                  r_class_valid <= 1'b0;
                  r_class_type  <= '0;
                  r_class_votes <= '0;
                  r_n           <= '0;
                  r_scan        <= '0;
                  for (int i = 0; i < N_TYPES; i++) r_cnt[i] <= '0;
               end
            end
            default: r_state <= ST_COLLECT;
         endcase
      end
   end

   // Ordering check; the flag survives the handshake and is only dropped by
   // the first transfer of the following stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev      <= '0;
         r_have_prev <= 1'b0;
         r_err       <= 1'b0;
      end else if (w_xfer) begin
         r_prev      <= in_dist;
         r_have_prev <= 1'b1;
         r_err       <= r_have_prev && (r_err || (in_dist < r_prev));
      end else if (w_done) begin
         r_prev      <= '0;
         r_have_prev <= 1'b0;
      end
   end

   knn_argmax #(
      .TYPE_W (TYPE_W),
      .VW     (VW)
   ) u_argmax (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_done),
      .i_en        (w_scan_en),
      .i_idx       (w_scan_idx),
      .i_cnt       (r_cnt[w_scan_idx]),
      .o_best_type (w_best_type),
      .o_best_cnt  (w_best_cnt)
   );

   assign class_valid = r_class_valid;
   assign class_type  = r_class_valid ? r_class_type  : '0;
   assign class_votes = r_class_valid ? r_class_votes : '0;
   assign order_err   = r_err;

endmodule

// File: tb/tb_knn_vote.sv
// Directed-vector bench for knn_vote (K=5, TYPE_W=2, W=16) with a result
// scoreboard checked by an independent monitor.
module tb_knn_vote;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_dist = '0;
   logic [1:0]  in_type = '0;
   logic        in_last = 1'b0;
   logic        class_valid;
   logic        class_ready = 1'b1;
   logic [1:0]  class_type;
   logic [2:0]  class_votes;
   logic        order_err;

   typedef struct {
      int ty;
      int votes;
      int err;
      int last_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   logic prev_valid = 1'b0;

   knn_vote #(.W(16), .TYPE_W(2), .K(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_dist     (in_dist),
      .in_type     (in_type),
      .in_last     (in_last),
      .class_valid (class_valid),
      .class_ready (class_ready),
      .class_type  (class_type),
      .class_votes (class_votes),
      .order_err   (order_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each rising class_valid.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (class_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result got type %0d want none", class_type);
            end else begin
               e = sb.pop_front();
               chk("class_type", int'(class_type), e.ty);
               chk("class_votes", int'(class_votes), e.votes);
               chk("order_err", int'(order_err), e.err);
               chk("latency", cyc - e.last_cyc, 5);
            end
         end
         if (!class_valid) begin
            chk("type_idle_zero", int'(class_type), 0);
            chk("votes_idle_zero", int'(class_votes), 0);
         end
      end
      prev_valid = class_valid;
   end

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send(input int d, input int t, input bit last);
      int guard = 0;
      in_valid = 1'b1;
      in_dist  = 16'(d);
      in_type  = 2'(t);
      in_last  = last;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got in_ready 0 want 1");
      end
      @(posedge clk);
      @(negedge clk);
      if (last) last_cyc = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result();
      int guard = 0;
      while (!class_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!class_valid) begin
         checks++;
         errors++;
         $display("FAIL result_timeout got class_valid 0 want 1");
      end
   endtask

   task automatic run_stream(input int ty[8], input int ds[8], input int n,
                             input int ety, input int evotes, input int eerr);
      for (int i = 0; i < n; i++) send(ds[i], ty[i], i == n - 1);
      sb.push_back('{ety, evotes, eerr, last_cyc});
      wait_result();
      @(negedge clk);
   endtask

   initial begin
      int g;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_valid", int'(class_valid), 0);
      chk("rst_err", int'(order_err), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(in_ready), 1);

      // Eight samples, DRAIN path: label 1 holds 3 of the first 5.
      run_stream('{1, 1, 2, 1, 3, 0, 0, 0}, '{1, 2, 3, 4, 5, 6, 7, 8}, 8, 1, 3, 0);
      // Tie 2 vs 3 at two votes each goes to the lower label; equal distances legal.
      run_stream('{2, 3, 3, 2, 0, 0, 0, 0}, '{5, 6, 6, 7, 0, 0, 0, 0}, 4, 2, 2, 0);
      // Short stream.
      run_stream('{3, 3, 0, 0, 0, 0, 0, 0}, '{4, 9, 0, 0, 0, 0, 0, 0}, 2, 3, 2, 0);
      // Descending step raises the sticky error.
      run_stream('{0, 1, 1, 0, 0, 0, 0, 0}, '{10, 8, 9, 0, 0, 0, 0, 0}, 3, 1, 2, 1);
      chk("err_sticky_after_result", int'(order_err), 1);

      // Next stream clears the error on its first transfer; consumer stalls 3 cycles.
      class_ready = 1'b0;
      send(1, 0, 1'b0);
      chk("err_clear_first_xfer", int'(order_err), 0);
      send(2, 0, 1'b0);
      send(3, 0, 1'b1);
      sb.push_back('{0, 3, 0, last_cyc});
      wait_result();
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", int'(class_valid), 1);
         chk("stall_type", int'(class_type), 0);
         chk("stall_votes", int'(class_votes), 3);
         chk("stall_in_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      class_ready = 1'b1;
      @(negedge clk);
      chk("handshake_in_ready", int'(in_ready), 1);
      chk("handshake_valid", int'(class_valid), 0);

      // Reset mid-stream, with an ordering error pending.
      send(5, 0, 1'b0);
      send(3, 0, 1'b0);
      send(4, 1, 1'b0);
      chk("pre_rst_err", int'(order_err), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 0);
      chk("mid_rst_valid", int'(class_valid), 0);
      chk("mid_rst_type", int'(class_type), 0);
      chk("mid_rst_votes", int'(class_votes), 0);
      chk("mid_rst_err", int'(order_err), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_in_ready", int'(in_ready), 1);
      run_stream('{0, 0, 1, 1, 1, 0, 0, 0}, '{1, 2, 3, 4, 5, 0, 0, 0}, 5, 1, 3, 0);

      g = 0;
      while (sb.size() != 0 && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/knn_vote.md
KNN_VOTE -- requirements
Module: knn_vote

Interface
REQ-001 Parameter W, default 16: width of a distance value.
REQ-002 Parameter TYPE_W, default 2: width of a class label; N_TYPES = 2**TYPE_W.
REQ-003 Parameter K, default 5: number of nearest neighbours that vote; legal range 1..255; VW = clog2(K+1).
REQ-004 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port in_valid  in  1  sorted-stream sample present.
REQ-007 Port in_ready  out  1  block accepts sample; a transfer occurs when in_valid and in_ready are both high.
REQ-008 Port in_dist  in  W  sample distance; the stream is ascending, nearest neighbour first.
REQ-009 Port in_type  in  TYPE_W  sample class label.
REQ-010 Port in_last  in  1  marks the final sample of a stream.
REQ-011 Port class_valid  out  1  classification result present.
REQ-012 Port class_ready  in  1  consumer accepts the result.
REQ-013 Port class_type  out  TYPE_W  winning label.
REQ-014 Port class_votes  out  VW  vote count of the winning label.
REQ-015 Port order_err  out  1  sticky flag: the stream was not ascending.

Function
REQ-016 The FSM SHALL have four states: COLLECT, DRAIN, VOTE, RESULT.
- Reset state is COLLECT.
- in_ready is high only in COLLECT and DRAIN.
REQ-017 COLLECT SHALL handle each transfer as follows:
- Increment counter cnt[in_type], saturating at K.
- Increment accepted-sample count n.
- Store in_dist as prev_dist.
REQ-018 When transfer n == K without in_last, the FSM SHALL go to DRAIN. Later transfers are consumed with no count update.
REQ-019 A transfer with in_last, in COLLECT or DRAIN, SHALL move the FSM to VOTE on the next edge.
- If in_last arrives in COLLECT before K samples, the vote covers only the samples received.
- If in_last coincides with the K-th sample, go directly to VOTE, never DRAIN.
REQ-020 VOTE SHALL scan label indices 0..N_TYPES-1, one per cycle.
- Maintain best_type and best_cnt.
- Replace the current best only when cnt[i] > best_cnt (strict), so ties go to the lower label index.
REQ-021 RESULT SHALL follow the final scan cycle.
- class_valid rises exactly N_TYPES+1 edges after the in_last transfer edge.
REQ-022 In RESULT, class_valid, class_type and class_votes SHALL stay stable until class_ready is high.
- On that edge, return to COLLECT.
- Clear all cnt, n, prev_dist and best registers.
REQ-023 order_err SHALL set on any counted or drained transfer whose in_dist < prev_dist; equal distances are legal.
- It stays high through RESULT.
- It clears on the first transfer of the next stream.
REQ-024 The first transfer of a stream SHALL never raise order_err.
REQ-025 class_type and class_votes SHALL read 0 whenever class_valid is low.

Reset
REQ-026 Asserting rst at any time, including mid-stream or in RESULT, SHALL immediately force the following:
- state = COLLECT.
- in_ready = 0 while rst is high.
- class_valid = 0, class_type = 0, class_votes = 0, order_err = 0.
- All counters cleared.
REQ-027 After rst deasserts, in_ready SHALL be 1 on the first cycle; no partial stream survives reset.

Structure
REQ-028 Package knn_pkg SHALL hold:
- The FSM state enum.
- Default values for K, W and TYPE_W.
- The VW width function, shared with the sort network.
REQ-029 The label scan SHALL be sub-module knn_argmax: sequential compare-and-hold of best index and count, with strict-greater update.
REQ-030 The vote counters SHALL be a register array of N_TYPES entries, VW bits each.

Verification (K=5, TYPE_W=2, W=16)
REQ-031 Types 1,1,2,1,3,0,0,0 with ascending distances, last on the 8th -> class_type=1, class_votes=3, class_valid 5 edges after last, order_err=0.
REQ-032 Types 2,3,3,2, last on the 4th -> tie at 2 votes -> class_type=2, class_votes=2.
REQ-033 Two samples, types 3,3, last on the 2nd -> class_type=3, class_votes=2, no DRAIN visit.
REQ-034 Distances 10,8,9 (last on the 3rd) -> order_err=1 through RESULT; the next stream's first transfer clears it.
REQ-035 class_ready held low 3 cycles in RESULT -> outputs stable and in_ready=0; handshake on the 4th cycle -> in_ready=1 on the next cycle.
REQ-036 rst pulsed after 3 of 5 samples -> all outputs 0; a fresh stream of types 0,0,1,1,1 then yields class_type=1, class_votes=3.
